// File: rtl/mul_sequencer.sv
// Iterative shift-add multiplier with an EX-stage stall controller: a MUL in EX
// holds the pipeline while the low WIDTH bits of the product are accumulated.
module mul_sequencer #(
   parameter int WIDTH      = 32,
   parameter bit EARLY_EXIT = 1'b1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             valid_i,
   input  logic [2:0]       ALUCtrl_i,
   input  logic             flush_i,
   input  logic [WIDTH-1:0] data1_i,
   input  logic [WIDTH-1:0] data2_i,
   output logic             stall_o,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] result_o
);

   localparam logic [2:0] ALU_MUL = 3'b111;
   localparam int         CW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_next;
   logic [WIDTH-1:0] acc, mcand, mplier;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] acc_upd, mplier_upd;
   logic             start, run_exit;

   // Handshake: a valid MUL in EX is accepted only in IDLE; stall_o holds the
   // upstream stages from that cycle until DONE, when done_o marks result_o valid.
   assign start      = valid_i && (ALUCtrl_i == ALU_MUL) && (state == IDLE) && !flush_i;
   assign acc_upd    = acc + (mplier[0] ? mcand : '0);
   assign mplier_upd = mplier >> 1;
   // count still holds the pre-increment value, so the WIDTH-th RUN cycle exits
   assign run_exit   = (count == CW'(WIDTH - 1)) || (EARLY_EXIT && (mplier_upd == '0));

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (run_exit) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (flush_i) state_next = IDLE;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state    <= IDLE;
         acc      <= '0;
         mcand    <= '0;
         mplier   <= '0;
         count    <= '0;
         result_o <= '0;
      end else begin
         state <= state_next;
         case (state)
            IDLE: begin
               if (start) begin
                  mcand  <= data1_i;
                  mplier <= data2_i;
                  acc    <= '0;
                  count  <= '0;
               end
            end
            RUN: begin
               acc    <= acc_upd;
               mcand  <= mcand << 1;
               mplier <= mplier_upd;
               count  <= count + 1'b1;
               if (run_exit && !flush_i) result_o <= acc_upd;
            end
            default: ;
         endcase
      end
   end

   assign stall_o = !rst_i && (((state == IDLE) && start) || (state == RUN));
   assign busy_o  = (state == RUN);
   assign done_o  = (state == DONE);

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed bench for mul_sequencer: one full-length instance and one early-exit
// instance share the stimulus; each scenario observes the relevant instance.
module tb_mul_sequencer;

   logic        clk;
   logic        rst;
   logic        valid;
   logic [2:0]  alu_ctrl;
   logic        flush;
   logic [31:0] data1, data2;

   logic        stall0, busy0, done0;
   logic [31:0] result0;
   logic        stall1, busy1, done1;
   logic [31:0] result1;

   logic        sel;
   logic        obs_stall, obs_busy, obs_done;
   logic [31:0] obs_result;

   int n_checks = 0;
   int n_fail   = 0;

   mul_sequencer #(.WIDTH(32), .EARLY_EXIT(1'b0)) dut_full (
      .clk_i(clk), .rst_i(rst), .valid_i(valid), .ALUCtrl_i(alu_ctrl),
      .flush_i(flush), .data1_i(data1), .data2_i(data2),
      .stall_o(stall0), .busy_o(busy0), .done_o(done0), .result_o(result0)
   );

   mul_sequencer #(.WIDTH(32), .EARLY_EXIT(1'b1)) dut_early (
      .clk_i(clk), .rst_i(rst), .valid_i(valid), .ALUCtrl_i(alu_ctrl),
      .flush_i(flush), .data1_i(data1), .data2_i(data2),
      .stall_o(stall1), .busy_o(busy1), .done_o(done1), .result_o(result1)
   );

   assign obs_stall  = sel ? stall1  : stall0;
   assign obs_busy   = sel ? busy1   : busy0;
   assign obs_done   = sel ? done1   : done0;
   assign obs_result = sel ? result1 : result0;

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got running, required finished");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      valid    = 1'b0;
      alu_ctrl = 3'b000;
      flush    = 1'b0;
      data1    = '0;
      data2    = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   // start at cycle 0 with the MUL held until DONE, then released
   task automatic run_mul(input logic s, input logic [31:0] a, input logic [31:0] b,
                          input int done_cyc, input logic [31:0] exp_res);
      sel      = s;
      valid    = 1'b1;
      alu_ctrl = 3'b111;
      flush    = 1'b0;
      data1    = a;
      data2    = b;
      for (int c = 0; c <= done_cyc; c++) begin
         #1;
         if (c < done_cyc) begin
            check("stall_while_mul", {31'd0, obs_stall}, 32'd1);
            check("no_early_done",   {31'd0, obs_done},  32'd0);
            check("busy_in_run",     {31'd0, obs_busy},  {31'd0, (c > 0)});
         end else begin
            check("stall_released", {31'd0, obs_stall}, 32'd0);
            check("done_pulse",     {31'd0, obs_done},  32'd1);
            check("busy_in_done",   {31'd0, obs_busy},  32'd0);
            check("result",         obs_result,         exp_res);
         end
         step();
      end
      valid = 1'b0;
      #1;
      check("no_restart_busy", {31'd0, obs_busy},  32'd0);
      check("done_one_cycle",  {31'd0, obs_done},  32'd0);
      check("stall_after",     {31'd0, obs_stall}, 32'd0);
      check("result_held",     obs_result,         exp_res);
      step();
      check("result_held2",    obs_result,         exp_res);
   endtask

   initial begin
      rst = 1'b1;
      sel = 1'b1;
      idle_inputs();
      do_reset();

      // reset state of both instances
      #1;
      check("rst_stall0",  {31'd0, stall0}, 32'd0);
      check("rst_busy0",   {31'd0, busy0},  32'd0);
      check("rst_done0",   {31'd0, done0},  32'd0);
      check("rst_result0", result0,         32'd0);
      check("rst_stall1",  {31'd0, stall1}, 32'd0);
      check("rst_result1", result1,         32'd0);

      // reset in the middle of a run (7 * 0xF0, highest bit 7)
      sel = 1'b1; valid = 1'b1; alu_ctrl = 3'b111; data1 = 32'd7; data2 = 32'hF0;
      step(); step(); step();
      check("busy_before_rst", {31'd0, busy1}, 32'd1);
      rst = 1'b1;
      #1;
      check("rst_forces_stall0", {31'd0, stall0}, 32'd0);
      check("rst_forces_stall1", {31'd0, stall1}, 32'd0);
      step();
      check("rst_forces_stall1b", {31'd0, stall1}, 32'd0);
      step();
      rst = 1'b0;
      valid = 1'b0;
      #1;
      check("midrst_stall", {31'd0, stall1}, 32'd0);
      check("midrst_busy",  {31'd0, busy1},  32'd0);
      check("midrst_done",  {31'd0, done1},  32'd0);
      check("midrst_result", result1,        32'd0);
      step();

      // clean start after reset; signed -3 * 5 with early exit
      run_mul(1'b1, 32'hFFFF_FFFD, 32'd5, 4, 32'hFFFF_FFF1);
      do_reset();
      // 3 * -3: multiplier top bit set, full 32 RUN cycles
      run_mul(1'b1, 32'd3, 32'hFFFF_FFFD, 33, 32'hFFFF_FFF7);
      do_reset();
      // zero multiplier
      run_mul(1'b1, 32'd123, 32'd0, 2, 32'd0);
      do_reset();

      // full-length 7 * 6 on the non-early-exit instance
      run_mul(1'b0, 32'd7, 32'd6, 33, 32'd42);

      // flush in RUN cycle 5; result keeps 42
      sel = 1'b0; valid = 1'b1; alu_ctrl = 3'b111; data1 = 32'd9; data2 = 32'd9;
      for (int c = 0; c < 5; c++) step();
      flush = 1'b1;
      #1;
      check("flush_stall_follows_run", {31'd0, stall0}, 32'd1);
      check("flush_busy_in_run",       {31'd0, busy0},  32'd1);
      step();
      flush = 1'b0;
      valid = 1'b0;
      #1;
      check("flush_idle_busy",  {31'd0, busy0},  32'd0);
      check("flush_idle_stall", {31'd0, stall0}, 32'd0);
      check("flush_no_done",    {31'd0, done0},  32'd0);
      check("flush_result",     result0,         32'd42);
      for (int c = 0; c < 3; c++) begin
         step();
         check("flush_no_late_done", {31'd0, done0}, 32'd0);
      end
      check("flush_result_kept", result0, 32'd42);
      do_reset();

      // non-MUL codes never start or stall
      valid = 1'b1;
      for (int c = 0; c < 10; c++) begin
         case (c % 4)
            0: alu_ctrl = 3'b010;
            1: alu_ctrl = 3'b000;
            2: alu_ctrl = 3'b001;
            default: alu_ctrl = 3'b110;
         endcase
         data1 = 32'd5; data2 = 32'd7;
         #1;
         check("nonmul_stall0", {31'd0, stall0}, 32'd0);
         check("nonmul_stall1", {31'd0, stall1}, 32'd0);
         step();
         check("nonmul_busy0", {31'd0, busy0}, 32'd0);
         check("nonmul_busy1", {31'd0, busy1}, 32'd0);
      end
      // MUL code without valid
      valid = 1'b0;
      alu_ctrl = 3'b111;
      for (int c = 0; c < 4; c++) begin
         #1;
         check("invalid_mul_stall", {31'd0, stall1}, 32'd0);
         step();
         check("invalid_mul_busy", {31'd0, busy1}, 32'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
